// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU instruction path: word layout, special
// opcodes and the issuer state encoding.
package cpu_pkg;

    localparam int WORD_W   = 20;
    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_HALT = 4'hF;

    localparam logic [WORD_W-1:0] NOP_WORD = 20'h00000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } issuer_state_t;

    // Opcode field of an instruction word (top OPCODE_W bits).
    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [WORD_W-1:0] w);
        return w[WORD_W-1 -: OPCODE_W];
    endfunction

endpackage

// File: rtl/issuer_prog_mem.sv
// Program store for instr_issuer: DEPTH x WORD_W register file with one
// synchronous write port and one combinational read port. Not reset, so
// a loaded program survives rst.
module issuer_prog_mem
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Synchronous write; the new word is readable the cycle after.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issuer.sv
// Program sequencer feeding the core's instruction input. On start it walks
// the program store from address 0, one word per cycle, until HALT, the
// final-address wrap, or abort.
// Optional feature macro: ISSUER_JUMP_EN (opcode 4'hE becomes JUMP).
module instr_issuer
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [19:0]       prog_wdata,
    input  logic              start,
    input  logic              hold,
    input  logic              abort,
    output logic [19:0]       instr_out,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);

    issuer_state_t     state, state_n;
    logic [ADDR_W-1:0] pc_n;
    logic [WORD_W-1:0] out_n;
    logic              valid_n;
    logic [WORD_W-1:0] word;
    logic              mem_we;

    // Loader writes are only accepted while idle.
    assign mem_we = prog_we && (state == IDLE);

    issuer_prog_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (pc),
        .rdata (word)
    );

    // State, PC and registered instruction outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            instr_out   <= NOP_WORD;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr_out   <= out_n;
            instr_valid <= valid_n;
        end
    end

    // Next-state, next-PC and next-output decode; NOP is the default word.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        out_n   = NOP_WORD;
        valid_n = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    pc_n    = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = DONE;
                end else if (hold) begin
                    state_n = RUN;
                end else if (opcode_of(word) == OP_HALT) begin
                    state_n = DONE;
`ifdef ISSUER_JUMP_EN
                end else if (opcode_of(word) == OP_JMP) begin
                    pc_n = word[ADDR_W-1:0];
`endif
                end else begin
                    out_n   = word;
                    valid_n = 1'b1;
                    pc_n    = pc + ADDR_W'(1);
                    if (pc == ADDR_W'(DEPTH - 1)) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: doc/instr_issuer.md
# instr_issuer

Program sequencer that drives the 20-bit instruction word stream into the CPU core's instruction input. It holds a small writable program store, and on `start` walks it from address 0, presenting one word per cycle as `{opcode[3:0], operand[15:0]}`. A pipeline hold stalls the walk, and a HALT opcode, a final-address wrap or `abort` ends the run. It sits between the test/host loader and the core; `instr_out` connects directly to the core's `data_in`.

## Interface
Parameters:
- `DEPTH`, 16: number of program words (power of two).
- `ADDR_W`, 4: program address width, equal to log2(DEPTH).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `prog_we`  in  1  program write strobe; honoured only in IDLE.
- `prog_addr`  in  ADDR_W  program write address.
- `prog_wdata`  in  20  program word to write.
- `start`  in  1  begin a run at address 0; sampled only in IDLE.
- `hold`  in  1  stall; while high, no word is fetched and the PC is frozen.
- `abort`  in  1  terminate the current run.
- `instr_out`  out  20  instruction word to the core; NOP (20'h00000) when not valid.
- `instr_valid`  out  1  `instr_out` carries a program word this cycle.
- `pc`  out  ADDR_W  address of the next word to fetch.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a run ends.

## Operation
- States and transitions:
  - IDLE, on `start`: go to RUN with `pc`=0.
  - RUN, on HALT, wrap or `abort`: go to DONE.
  - DONE: always returns to IDLE on the next cycle.
- Fetch in RUN with `hold`=0 and `abort`=0, looking at word `w`=mem[`pc`]:
  - Opcode of `w` is not 4'hF: register `instr_out`=`w`, assert `instr_valid`, `pc`+1.
  - Opcode of `w` is 4'hF (HALT): the word is not issued. `instr_out`=NOP, `instr_valid`=0, go to DONE, `pc` unchanged.
  - `pc`==DEPTH-1 and the word is issued: the word is output, `pc` wraps to 0, next state is DONE.
- `hold`=1 in RUN: `instr_out`=NOP, `instr_valid`=0, `pc` frozen. The NOP keeps the core from re-executing the previous word.
- `abort` in RUN has priority over `hold` and over fetch: `instr_out`=NOP, go to DONE.
- In IDLE and DONE: `instr_out`=NOP, `instr_valid`=0.
- `prog_we` outside IDLE is ignored. `start` outside IDLE is ignored.
- `prog_we` and `start` in the same IDLE cycle: the write completes and the run starts. The run sees the new word.
- Reset values: `instr_out`=20'h00000, `instr_valid`=0, `pc`=0, `busy`=0, `done`=0, state=IDLE. The program store is not reset and its contents survive `rst`.
- Reset mid-run: asynchronous return to IDLE; no `done` pulse.

## Timing
- `start` sampled at edge k: state is RUN and `pc`=0 after edge k.
- After edge k+1: `instr_out`=mem[0], `instr_valid`=1.
- Steady throughput is one word per cycle.
- HALT fetched at edge m: `done`=1 after edge m (the DONE cycle), IDLE after edge m+1.
- `busy` and `done` are decoded directly from the state register.
- `instr_out` and `instr_valid` are registered.
- A program write is visible to a fetch on the cycle after the write.

## Configuration
- Macro `ISSUER_JUMP_EN`.
- Defined: opcode 4'hE is JUMP.
  - On fetch, JUMP is not issued: `instr_out`=NOP, `instr_valid`=0.
  - `pc` is loaded with `operand[ADDR_W-1:0]` and the state stays RUN.
  - Loops are allowed and are ended only by HALT, `abort` or `rst`.
- Not defined: 4'hE is an ordinary opcode and is issued unchanged.

## Structure
- Shared package `cpu_pkg`:
  - `WORD_W`=20, `OPCODE_W`=4.
  - `OP_NOP`=4'h0, `OP_JMP`=4'hE, `OP_HALT`=4'hF, `NOP_WORD`=20'h00000.
  - State enum `issuer_state_t` {IDLE, RUN, DONE}.
- Sub-module `issuer_prog_mem`: DEPTH×20 register-file program store with one synchronous write port and one combinational read port addressed by `pc`.

## Test plan
- Program mem[0..2]=20'h1_0005, 20'h2_0003, 20'hF_0000; pulse `start`:
  - Two cycles later `instr_out` is 20'h10005, then 20'h20003, both with `instr_valid`=1.
  - Next cycle: NOP with `done`=1. Then IDLE.
- Same program, `hold`=1 for 2 cycles after the first word: NOP for 2 cycles, `pc` stays 1, then 20'h20003 is issued.
- 16 non-HALT words: all 16 issued in order, `pc` wraps to 0, `done` pulses after the 16th word.
- `abort` raised together with `hold` on the 2nd RUN cycle: next cycle `done`=1 and `instr_out`=NOP. A `prog_we` in that DONE cycle is ignored.
- `rst` asserted mid-run: outputs return to 0 at once. A rerun with `start` replays the same words, proving the program store was retained.
- With `ISSUER_JUMP_EN`, mem[2]=20'hE_0000 and `abort` after 7 cycles: words 0,1 are issued, a NOP appears for the jump, the sequence repeats, and `done` pulses after `abort`.
